// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing one byte transmitter (tx_module) among NREQ
// requesters. It latches the winner's byte and holds tx_en for the whole
// frame. It then pulses done (tx_done seen) or err (watchdog expired) back
// to the winner. A one-cycle GAP state follows every frame.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   req      [NREQ]     per-requester level request, held with data until grant
//   req_data [8*NREQ]   byte of requester i on [8i+7:8i]
//   grant    [NREQ]     one-hot pulse: byte of requester i captured
//   done     [NREQ]     one-hot pulse: byte of requester i fully sent
//   err      [NREQ]     one-hot pulse: byte of requester i aborted by watchdog
//   busy                high whenever the arbiter is not idle
//   tx_en, tx_data      level enable and byte to the transmitter
//   tx_done             end-of-frame pulse from the transmitter
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 60000,
  parameter int CNT_W       = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  input  logic              tx_done
);

  localparam int          IDX_W   = $clog2(NREQ);
  localparam int unsigned NREQ_U  = NREQ;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] last, last_nx;
  logic [IDX_W-1:0] sel, sel_nx;
  logic [CNT_W-1:0] wdog, wdog_nx;
  logic             tx_en_nx;
  logic [7:0]       tx_data_nx;
  logic [NREQ-1:0]  grant_nx, done_nx, err_nx;

  logic [IDX_W-1:0] pick;
  logic             found;

  // Scan from the requester after the last winner, wrapping, so the most
  // recently served requester has the lowest priority.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= NREQ_U; off++) begin
      if (!found && req[IDX_W'((32'(last) + off) % NREQ_U)]) begin
        found = 1'b1;
        pick  = IDX_W'((32'(last) + off) % NREQ_U);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    last_nx    = last;
    sel_nx     = sel;
    wdog_nx    = wdog;
    tx_en_nx   = tx_en;
    tx_data_nx = tx_data;
    grant_nx   = '0;
    done_nx    = '0;
    err_nx     = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          sel_nx     = pick;
          last_nx    = pick;
          tx_data_nx = req_data[8*pick +: 8];
          grant_nx   = NREQ'(1) << pick;
          tx_en_nx   = 1'b1;
          wdog_nx    = '0;
          state_nx   = SEND;
        end
      end
      SEND: begin
        wdog_nx = wdog + CNT_W'(1);
        // tx_done wins over a watchdog expiry in the same cycle.
        if (tx_done) begin
          tx_en_nx = 1'b0;
          done_nx  = NREQ'(1) << sel;
          state_nx = GAP;
        end else if (wdog == WD_LAST) begin
          tx_en_nx = 1'b0;
          err_nx   = NREQ'(1) << sel;
          state_nx = GAP;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= IDX_W'(NREQ - 1);
      sel     <= '0;
      wdog    <= '0;
      tx_en   <= 1'b0;
      tx_data <= '0;
      grant   <= '0;
      done    <= '0;
      err     <= '0;
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      sel     <= sel_nx;
      wdog    <= wdog_nx;
      tx_en   <= tx_en_nx;
      tx_data <= tx_data_nx;
      grant   <= grant_nx;
      done    <= done_nx;
      err     <= err_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 20;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   grant, done, err;
  logic           busy, tx_en;
  logic [7:0]     tx_data;
  logic           tx_done = 1'b0;

  uart_tx_arbiter #(.NREQ(N), .TIMEOUT_CYC(T), .CNT_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .err(err), .busy(busy),
    .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transmitter emulation ----------------
  // tx_done fires in the cycle where the frame has been running emu_len
  // cycles; emu_len >= T means the frame never finishes.
  int emu_cnt   = 0;
  int emu_len   = 5;
  int stray_pct = 0;
  bit emu_rand  = 1'b0;

  always @(posedge clk) begin
    #1;
    if (tx_en) begin
      tx_done = (emu_cnt == emu_len);
      emu_cnt++;
    end else begin
      emu_cnt = 0;
      if (emu_rand) begin
        case ($urandom_range(9))
          7:       emu_len = T - 1;
          8:       emu_len = T - 2;
          9:       emu_len = 1000;
          default: emu_len = int'($urandom_range(8));
        endcase
      end
      tx_done = (int'($urandom_range(99)) < stray_pct);
    end
  end

  // ---------------- reference model ----------------
  // Transaction view: current owner (-1 = none), cycles spent sending,
  // and whether the frame has ended (post cycle shows done/err).
  int         m_cur, m_age, m_post, m_last;
  bit         m_err;
  logic [7:0] m_data;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int o = 1; o <= N; o++)
      if (r[(last + o) % N]) return (last + o) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cur <= -1; m_age <= 0; m_post <= 0; m_last <= N - 1; m_err <= 1'b0; m_data <= 8'h00;
    end else if (m_cur < 0) begin
      if (req != '0) begin
        m_cur  <= rr_pick(req, m_last);
        m_last <= rr_pick(req, m_last);
        m_data <= req_data[8*rr_pick(req, m_last) +: 8];
        m_age  <= 0;
      end
    end else if (m_post == 0) begin
      if (tx_done) begin
        m_post <= 1; m_err <= 1'b0;
      end else if (m_age == T - 1) begin
        m_post <= 1; m_err <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end else begin
      m_cur <= -1; m_post <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("grant",   32'(grant),   (m_cur >= 0 && m_post == 0 && m_age == 0) ? (32'd1 << m_cur) : 32'd0);
      check("tx_en",   32'(tx_en),   (m_cur >= 0 && m_post == 0) ? 32'd1 : 32'd0);
      check("tx_data", 32'(tx_data), 32'(m_data));
      check("done",    32'(done),    (m_post == 1 && !m_err) ? (32'd1 << m_cur) : 32'd0);
      check("err",     32'(err),     (m_post == 1 && m_err) ? (32'd1 << m_cur) : 32'd0);
      check("busy",    32'(busy),    (m_cur >= 0) ? 32'd1 : 32'd0);
    end
  end

  // ---------------- directed helpers ----------------
  // One frame from requester 0; n = cycles from grant to the done/err pulse.
  task automatic run_one(input logic [7:0] d, input int len, output int n,
                         output logic [N-1:0] d_o, output logic [N-1:0] e_o);
    int w;
    @(posedge clk); #1;
    emu_len = len; req = 4'b0001; req_data[7:0] = d;
    w = 0;
    do begin @(negedge clk); w++; end while (grant == '0 && w < 50);
    check("grant_latency", 32'(w), 32'd2);
    check("grant_onehot", 32'(grant), 32'h1);
    check("captured_byte", 32'(tx_data), 32'(d));
    @(posedge clk); #1;
    req = '0; req_data[7:0] = ~d;
    n = 1;
    @(negedge clk);
    while (done == '0 && err == '0 && n < 100) begin @(negedge clk); n++; end
    d_o = done; e_o = err;
    check("tx_en_low_at_end", 32'(tx_en), 32'd0);
  endtask

  task automatic next_grant(output logic [N-1:0] g);
    int w;
    w = 0;
    do begin @(negedge clk); w++; end while (grant == '0 && w < 100);
    if (grant == '0) check("grant_timeout", 32'd0, 32'd1);
    g = grant;
  endtask

  // ---------------- main sequence ----------------
  int n, m;
  logic [N-1:0] dv, ev, g;

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_data",  32'(tx_data), 32'd0);
    @(negedge clk); rst_n = 1'b1; chk_en = 1'b1;

    // single requester, normal frame
    run_one(8'h55, 5, n, dv, ev);
    check("single_latency", 32'(n), 32'd6);
    check("single_done", 32'(dv), 32'h1);
    check("single_err",  32'(ev), 32'h0);
    @(negedge clk);
    check("single_busy_after", 32'(busy), 32'd0);

    // watchdog expiry
    run_one(8'h3C, 1000, n, dv, ev);
    check("timeout_latency", 32'(n), 32'(T));
    check("timeout_err",  32'(ev), 32'h1);
    check("timeout_done", 32'(dv), 32'h0);

    // tx_done on the last watchdog cycle
    run_one(8'hC3, T - 1, n, dv, ev);
    check("coincide_latency", 32'(n), 32'(T));
    check("coincide_done", 32'(dv), 32'h1);
    check("coincide_err",  32'(ev), 32'h0);

    // stray tx_done while idle
    @(posedge clk); #1; stray_pct = 100;
    repeat (3) begin
      @(negedge clk);
      check("stray_done", 32'(done), 32'd0);
      check("stray_err",  32'(err),  32'd0);
      check("stray_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1; stray_pct = 0;

    // randomized traffic
    emu_rand = 1'b1; stray_pct = 10;
    repeat (1500) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && grant[i]) begin
          if ($urandom_range(1) == 0) req[i] = 1'b0;
          req_data[8*i +: 8] = 8'($urandom);
        end else if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
    end
    req = '0;
    repeat (40) @(negedge clk);
    emu_rand = 1'b0; stray_pct = 0;

    // reset in the middle of a frame
    @(posedge clk); #1;
    emu_len = 15; req = '1; req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    m = 0;
    do begin @(negedge clk); m++; end while (!tx_en && m < 50);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_en", 32'(tx_en), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_done",  32'(done),  32'd0);
    check("midrst_err",   32'(err),   32'd0);
    check("midrst_busy",  32'(busy),  32'd0);
    emu_len = 4;
    @(negedge clk); rst_n = 1'b1;

    // contention with all requesters held
    next_grant(g);
    for (int k = 0; k < 5; k++) begin
      check("rr_grant", 32'(g), 32'd1 << (k % N));
      check("rr_data", 32'(tx_data), 32'(8'hA0 + 8'(k % N)));
      m = 0;
      do begin @(negedge clk); m++; end while (done == '0 && err == '0 && m < 100);
      m = 0;
      do begin @(negedge clk); m++; end while (!tx_en && m < 20);
      check("rr_gap", 32'(m), 32'd2);
      g = grant;
    end
    @(posedge clk); #1; req = '0;
    repeat (15) @(negedge clk);

    // fairness: requester 0 held, requester 2 arrives mid-frame
    @(posedge clk); #1; emu_len = 6; req = 4'b0001;
    next_grant(g);
    check("fair_first", 32'(g), 32'h1);
    @(posedge clk); #1; req[2] = 1'b1; req_data[23:16] = 8'h77;
    next_grant(g);
    check("fair_second", 32'(g), 32'h4);
    check("fair_second_data", 32'(tx_data), 32'h77);
    @(posedge clk); #1; req[2] = 1'b0;
    next_grant(g);
    check("fair_third", 32'(g), 32'h1);
    @(posedge clk); #1; req = '0;
    repeat (15) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got no finish, required finish before %0t", $time);
    $fatal(1);
  end

endmodule
